// File: rtl/sdram_chan_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sdram_chan_arbiter
// Purpose  : Shares one 8-bit SDRAM controller channel among N requesters.
//            Requesters use a level req / one-cycle ack handshake. The block
//            picks a requester round-robin, latches its address, data and
//            direction, raises a fresh rd/wr strobe edge toward the
//            controller, tracks the controller busy flag and returns the read
//            byte (or echoes the write byte) together with the ack pulse.
// Ports    : clk, reset               clock, asynchronous active-high reset
//            req/req_we/req_addr/req_din   per-requester request bundle
//            ack, dout, grant         completion pulse, result byte, grant idx
//            ch_addr/ch_rd/ch_wr/ch_din    toward controller channel
//            ch_dout/ch_busy          from controller channel
// Revision : 1.0  initial release
// ============================================================================
module sdram_chan_arbiter #(
    parameter int N  = 4,
    parameter int AW = 25
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N-1:0]    req,
    input  logic [N-1:0]    req_we,
    input  logic [N*AW-1:0] req_addr,
    input  logic [N*8-1:0]  req_din,
    output logic [N-1:0]    ack,
    output logic [7:0]      dout,
    output logic [2:0]      grant,
    output logic [AW-1:0]   ch_addr,
    output logic            ch_rd,
    output logic            ch_wr,
    output logic [7:0]      ch_din,
    input  logic [7:0]      ch_dout,
    input  logic            ch_busy
);

    localparam logic [1:0] c_st_idle      = 2'd0;
    localparam logic [1:0] c_st_issue     = 2'd1;
    localparam logic [1:0] c_st_wait_busy = 2'd2;
    localparam logic [1:0] c_st_wait_done = 2'd3;

    logic [1:0]    r_state;
    logic [2:0]    r_ptr;
    logic [2:0]    r_grant;
    logic          r_we;
    logic [AW-1:0] r_addr;
    logic [7:0]    r_din;
    logic [7:0]    r_dout;
    logic          r_rd;
    logic          r_wr;
    logic [N-1:0]  r_ack;

    logic          w_found;
    logic [2:0]    w_idx;
    logic [AW-1:0] w_addr;
    logic [7:0]    w_din;
    logic          w_we;
    logic [2:0]    w_ptr_next;

    // Round-robin pick: the first pass only accepts requesters at or above
    // the pointer; if none is found the second pass takes the lowest set
    // request, which is then necessarily below the pointer (the wrap case).
    always_comb begin
        w_found = 1'b0;
        w_idx   = 3'd0;
        w_addr  = '0;
        w_din   = 8'd0;
        w_we    = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!w_found && req[i] && (3'(i) >= r_ptr)) begin
                w_found = 1'b1;
                w_idx   = 3'(i);
                w_addr  = req_addr[i*AW +: AW];
                w_din   = req_din[i*8 +: 8];
                w_we    = req_we[i];
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!w_found && req[i]) begin
                w_found = 1'b1;
                w_idx   = 3'(i);
                w_addr  = req_addr[i*AW +: AW];
                w_din   = req_din[i*8 +: 8];
                w_we    = req_we[i];
            end
        end
    end

    assign w_ptr_next = (r_grant == 3'(N-1)) ? 3'd0 : r_grant + 3'd1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_st_idle;
            r_ptr   <= 3'd0;
            r_grant <= 3'd0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_din   <= 8'd0;
            r_dout  <= 8'd0;
            r_rd    <= 1'b0;
            r_wr    <= 1'b0;
            r_ack   <= '0;
        end else begin
            r_ack <= '0;
            case (r_state)
                c_st_idle: begin
                    r_rd <= 1'b0;
                    r_wr <= 1'b0;
                    // A busy channel here means an operation is still in
                    // flight (e.g. one aborted by reset); never overlap it.
                    if (!ch_busy && w_found) begin
                        r_grant <= w_idx;
                        r_addr  <= w_addr;
                        r_din   <= w_din;
                        r_we    <= w_we;
                        r_state <= c_st_issue;
                    end
                end
                c_st_issue: begin
                    r_wr    <= r_we;
                    r_rd    <= ~r_we;
                    r_state <= c_st_wait_busy;
                end
                c_st_wait_busy: begin
                    // No timeout: the controller holds a pending edge through
                    // its init and refresh phases.
                    if (ch_busy) begin
                        r_rd    <= 1'b0;
                        r_wr    <= 1'b0;
                        r_state <= c_st_wait_done;
                    end
                end
                c_st_wait_done: begin
                    if (!ch_busy) begin
                        r_dout <= r_we ? r_din : ch_dout;
                        for (int i = 0; i < N; i++) begin
                            r_ack[i] <= (r_grant == 3'(i));
                        end
                        r_ptr   <= w_ptr_next;
                        r_state <= c_st_idle;
                    end
                end
                default: begin
                    r_rd    <= 1'b0;
                    r_wr    <= 1'b0;
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    assign ack     = r_ack;
    assign dout    = r_dout;
    assign grant   = r_grant;
    assign ch_addr = r_addr;
    assign ch_din  = r_din;
    assign ch_rd   = r_rd;
    assign ch_wr   = r_wr;

endmodule
`default_nettype wire

// File: tb/tb_sdram_chan_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sdram_chan_arbiter
// Purpose  : Self-checking bench for sdram_chan_arbiter (N=4, AW=25) with a
//            small behavioural model of the controller channel busy flag.
// Revision : 1.0  initial release
// ============================================================================
module tb_sdram_chan_arbiter;

    localparam int N  = 4;
    localparam int AW = 25;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [N-1:0]    req = '0;
    logic [N-1:0]    req_we = '0;
    logic [N*AW-1:0] req_addr = '0;
    logic [N*8-1:0]  req_din = '0;
    logic [N-1:0]    ack;
    logic [7:0]      dout;
    logic [2:0]      grant;
    logic [AW-1:0]   ch_addr;
    logic            ch_rd;
    logic            ch_wr;
    logic [7:0]      ch_din;
    logic [7:0]      ch_dout;
    logic            ch_busy;

    sdram_chan_arbiter #(.N(N), .AW(AW)) dut (
        .clk(clk), .reset(reset),
        .req(req), .req_we(req_we), .req_addr(req_addr), .req_din(req_din),
        .ack(ack), .dout(dout), .grant(grant),
        .ch_addr(ch_addr), .ch_rd(ch_rd), .ch_wr(ch_wr), .ch_din(ch_din),
        .ch_dout(ch_dout), .ch_busy(ch_busy)
    );

    always #5 clk = ~clk;

    // Controller channel model: a fresh strobe edge (seen one clock after
    // the DUT raises it) starts a busy_delay countdown, then busy is high
    // for busy_len+1 cycles. With this model the strobe stays high for
    // busy_delay+3 cycles.
    int         busy_delay = 0;
    int         busy_len   = 6;
    logic       fixed_mode = 1'b1;
    logic [7:0] m_rdata    = 8'h00;
    logic       hold_busy  = 1'b0;
    logic       m_busy     = 1'b0;
    logic       m_prev     = 1'b0;
    int         m_state    = 0;
    int         m_cnt      = 0;
    logic [7:0] m_dout     = 8'h00;

    always @(posedge clk) begin
        logic s;
        s = ch_rd | ch_wr;
        case (m_state)
            0: if (s && !m_prev) begin
                   m_cnt   = busy_delay;
                   m_state = 1;
                   m_dout <= fixed_mode ? m_rdata : (ch_addr[7:0] ^ 8'hA5);
               end
            1: if (m_cnt == 0) begin
                   m_busy <= 1'b1; m_cnt = busy_len; m_state = 2;
               end else m_cnt = m_cnt - 1;
            default: if (m_cnt == 0) begin
                   m_busy <= 1'b0; m_state = 0;
               end else m_cnt = m_cnt - 1;
        endcase
        m_prev = s;
    end

    assign ch_busy = m_busy | hold_busy;
    assign ch_dout = m_dout;

    // Event monitor, sampled on the falling edge.
    int   rd_edges = 0, wr_edges = 0, ack_cnt = 0, hi_cnt = 0;
    logic p_rd = 1'b0, p_wr = 1'b0;
    always @(negedge clk) begin
        if (ch_rd && !p_rd) rd_edges++;
        if (ch_wr && !p_wr) wr_edges++;
        if (ch_rd || ch_wr) hi_cnt++;
        if (ack != '0)      ack_cnt++;
        p_rd = ch_rd;
        p_wr = ch_wr;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    typedef struct {
        int         idx;
        logic       we;
        logic [24:0] addr;
        logic [7:0] din;
        logic [7:0] rdata;
        int         delay;
        logic [7:0] exp_dout;
        int         exp_hi;
    } vec_t;

    // Single operation on one requester; checks latency, result, latching
    // of the request bundle and that exactly one edge and one ack occur.
    task automatic do_txn(input vec_t v);
        int   rd0, wr0, ack0, hi0, lat;
        logic got;
        busy_delay = v.delay;
        m_rdata    = v.rdata;
        fixed_mode = 1'b1;
        req_we[v.idx]             = v.we;
        req_addr[v.idx*AW +: AW]  = v.addr;
        req_din[v.idx*8 +: 8]     = v.din;
        req[v.idx]                = 1'b1;
        rd0 = rd_edges; wr0 = wr_edges; ack0 = ack_cnt; hi0 = hi_cnt;
        lat = -1;
        got = 1'b0;
        for (int c = 1; c <= 300 && !got; c++) begin
            tick();
            if (lat < 0 && (ch_rd || ch_wr)) begin
                lat = c;
                // Changes after grant must not reach the channel.
                req_addr[v.idx*AW +: AW] = ~v.addr;
                req_din[v.idx*8 +: 8]    = ~v.din;
                req_we[v.idx]            = ~v.we;
            end
            if (ack != '0) got = 1'b1;
        end
        chk("txn_ack_seen", 32'(got), 32'd1);
        chk("txn_ack", 32'(ack), 32'(1 << v.idx));
        chk("txn_dout", 32'(dout), 32'(v.exp_dout));
        chk("txn_grant", 32'(grant), 32'(v.idx));
        chk("txn_ch_addr", 32'(ch_addr), 32'(v.addr));
        chk("txn_ch_din", 32'(ch_din), 32'(v.din));
        req[v.idx] = 1'b0;
        repeat (3) tick();
        chk("txn_latency", 32'(lat), 32'd2);
        chk("txn_rd_edges", 32'(rd_edges - rd0), v.we ? 32'd0 : 32'd1);
        chk("txn_wr_edges", 32'(wr_edges - wr0), v.we ? 32'd1 : 32'd0);
        chk("txn_ack_count", 32'(ack_cnt - ack0), 32'd1);
        chk("txn_strobe_high", 32'(hi_cnt - hi0), 32'(v.exp_hi));
    endtask

    // Hold a request mask continuously and check the grant order.
    task automatic run_rr(input logic [N-1:0] mask, input int n, input int exp_order[6]);
        int          rd0, ack0, k, g;
        logic [24:0] a;
        fixed_mode = 1'b0;
        busy_delay = 0;
        for (int i = 0; i < N; i++) begin
            a = 25'h0100000 + 25'(i * 16'h0111) + 25'h0042;
            req_addr[i*AW +: AW] = a;
            req_we[i] = 1'b0;
        end
        rd0 = rd_edges; ack0 = ack_cnt;
        req = mask;
        k = 0;
        for (int c = 0; c < 2000 && k < n; c++) begin
            tick();
            if (ack != '0) begin
                g = -1;
                for (int i = 0; i < N; i++) if (ack[i]) g = i;
                a = 25'h0100000 + 25'(exp_order[k] * 16'h0111) + 25'h0042;
                chk("rr_order", 32'(g), 32'(exp_order[k]));
                chk("rr_dout", 32'(dout), 32'(a[7:0] ^ 8'hA5));
                k++;
                if (k == n) req = '0;
            end
        end
        req = '0;
        chk("rr_ack_total_seen", 32'(k), 32'(n));
        repeat (3) tick();
        chk("rr_rd_edges", 32'(rd_edges - rd0), 32'(n));
        chk("rr_ack_count", 32'(ack_cnt - ack0), 32'(n));
    endtask

    vec_t vecs[5];
    vec_t v;
    int   order[6];
    int   rd0, ack0;
    logic done;

    initial begin
        //            idx we    addr           din    rdata  dly exp_dout exp_hi
        vecs[0] = '{0, 1'b0, 25'h0000123, 8'h11, 8'h5A, 0, 8'h5A, 3};
        vecs[1] = '{2, 1'b1, 25'h1FFFFFF, 8'hC3, 8'hEE, 0, 8'hC3, 3};
        vecs[2] = '{1, 1'b0, 25'h00ABCDE, 8'h00, 8'hA5, 0, 8'hA5, 3};
        vecs[3] = '{0, 1'b0, 25'h1000000, 8'h99, 8'hFF, 0, 8'hFF, 3};
        vecs[4] = '{3, 1'b1, 25'h0000000, 8'h7E, 8'h81, 2, 8'h7E, 5};

        repeat (3) tick();
        chk("rst_ch_rd", 32'(ch_rd), 32'd0);
        chk("rst_ch_wr", 32'(ch_wr), 32'd0);
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_dout", 32'(dout), 32'd0);
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_ch_addr", 32'(ch_addr), 32'd0);
        chk("rst_ch_din", 32'(ch_din), 32'd0);
        reset = 1'b0;
        repeat (2) tick();

        for (int i = 0; i < 5; i++) do_txn(vecs[i]);

        // Last grant was 3, so the pointer sits at 0.
        order = '{0, 1, 2, 3, 0, 1};
        run_rr(4'b1111, 6, order);

        // Pointer now 2; one grant to 2 moves it to 3 for the wrap check.
        v = '{2, 1'b0, 25'h0000456, 8'h01, 8'h3C, 0, 8'h3C, 3};
        do_txn(v);
        order = '{3, 0, 0, 0, 0, 0};
        run_rr(4'b1001, 2, order);
        v = '{0, 1'b0, 25'h0000789, 8'h02, 8'h4B, 0, 8'h4B, 3};
        do_txn(v);

        // Controller still initialising: busy rises 20 cycles late.
        v = '{1, 1'b0, 25'h0123456, 8'h03, 8'hD2, 20, 8'hD2, 23};
        do_txn(v);
        chk("long_busy_strobe_min", 32'(v.exp_hi >= 20), 32'd1);

        // Reset while waiting for the controller to finish.
        fixed_mode = 1'b1;
        busy_delay = 0;
        m_rdata    = 8'h3C;
        req_we[0] = 1'b0;
        req_addr[0 +: AW] = 25'h0000AAA;
        req[0] = 1'b1;
        done = 1'b0;
        for (int c = 0; c < 100 && !done; c++) begin
            tick();
            if (m_busy && !ch_rd && !ch_wr) done = 1'b1;
        end
        chk("rst_mid_reach_wait_done", 32'(done), 32'd1);
        hold_busy = 1'b1;
        req = 4'b0010;
        req_we[1] = 1'b0;
        req_addr[1*AW +: AW] = 25'h0000BBB;
        req_din[1*8 +: 8] = 8'h55;
        m_rdata = 8'h96;
        reset = 1'b1;
        #1;
        chk("rst_mid_ch_rd", 32'(ch_rd), 32'd0);
        chk("rst_mid_ack", 32'(ack), 32'd0);
        chk("rst_mid_grant", 32'(grant), 32'd0);
        tick();
        reset = 1'b0;
        rd0 = rd_edges; ack0 = ack_cnt;
        repeat (10) tick();
        chk("rst_mid_no_issue_while_busy", 32'(rd_edges - rd0), 32'd0);
        chk("rst_mid_no_ack_aborted", 32'(ack_cnt - ack0), 32'd0);
        hold_busy = 1'b0;
        done = 1'b0;
        for (int c = 0; c < 100 && !done; c++) begin
            tick();
            if (ack != '0) done = 1'b1;
        end
        chk("rst_mid_ack_seen", 32'(done), 32'd1);
        chk("rst_mid_ack_req1", 32'(ack), 32'b0010);
        chk("rst_mid_grant1", 32'(grant), 32'd1);
        chk("rst_mid_dout", 32'(dout), 32'h96);
        chk("rst_mid_ch_addr", 32'(ch_addr), 32'h0000BBB);
        req = '0;
        repeat (3) tick();
        chk("rst_mid_single_edge", 32'(rd_edges - rd0), 32'd1);
        chk("rst_mid_single_ack", 32'(ack_cnt - ack0), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
